// File: rtl/hicore_icb_pkg.sv
// Shared ICB constants, a constant-foldable clog2 and the arbiter state encoding.
// Pure declarations: no logic, no latency, no backpressure.
package hicore_icb_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [0:0] {
    ARBT_IDLE = 1'b0,
    ARBT_HOLD = 1'b1
  } arbt_state_e;

endpackage

// File: rtl/hicore_icb_rr_arbt_if.sv
// ICB bundle for NUM ports packed side by side; master issues commands, slave returns responses.
// Wires only: zero latency, backpressure carried by the cmd/rsp ready signals.
interface hicore_icb_rr_arbt_if #(
  parameter int NUM = 1,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NUM-1:0]        cmd_valid;
  logic [NUM-1:0]        cmd_ready;
  logic [NUM-1:0]        cmd_read;
  logic [NUM*AW-1:0]     cmd_addr;
  logic [NUM*DW-1:0]     cmd_wdata;
  logic [NUM*DW/8-1:0]   cmd_wmask;
  logic [NUM-1:0]        rsp_valid;
  logic [NUM-1:0]        rsp_ready;
  logic [NUM-1:0]        rsp_err;
  logic [NUM*DW-1:0]     rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/hicore_rspid_fifo.sv
// Small synchronous FIFO holding issuing-port IDs; write visible at the read side one cycle later.
// No full bypass: a write is refused while full even if a read happens in the same cycle.
module hicore_rspid_fifo
  import hicore_icb_pkg::*;
#(
  parameter int DW = 2,
  parameter int DP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [DW-1:0] wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DP > 1) ? clog2(DP) : 1;
  localparam int CW = clog2(DP + 1);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  assign full   = (cnt == CW'(DP));
  assign empty  = (cnt == '0);
  assign wr_rdy = ~full;
  assign rd_vld = ~empty;
  assign rd_dat = mem[rptr];
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/hicore_icb_rr_arbt.sv
// Round-robin N:1 ICB arbiter; zero-cycle command path, grant locked from first offer until handshake.
// Commands stall when OUTS_NUM are outstanding; responses return in order to the issuing port.
module hicore_icb_rr_arbt
  import hicore_icb_pkg::*;
#(
  parameter int AW         = ICB_AW,
  parameter int DW         = ICB_DW,
  parameter int ARBT_NUM   = 4,
  parameter int ARBT_PTR_W = 2,
  parameter int OUTS_NUM   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hicore_icb_rr_arbt_if.slave  i_bus,
  hicore_icb_rr_arbt_if.master o_icb
);
  arbt_state_e            state;
  logic [ARBT_PTR_W-1:0]  rr_ptr;
  logic [ARBT_PTR_W-1:0]  lock_id;
  logic [ARBT_PTR_W-1:0]  rr_grant;
  logic [ARBT_PTR_W-1:0]  grant;
  logic [ARBT_PTR_W-1:0]  idx;
  logic [ARBT_PTR_W-1:0]  head;
  logic                   found;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_wr_rdy;
  logic                   fifo_rd_vld;
  logic                   cmd_room;
  logic                   head_vld;
  logic                   cmd_hs;
  logic                   rsp_pop;
  logic [ARBT_NUM-1:0]    cmd_rdy_vec;
  logic [ARBT_NUM-1:0]    rsp_vld_vec;

  logic [AW-1:0]          addr_a  [ARBT_NUM];
  logic [DW-1:0]          wdata_a [ARBT_NUM];
  logic [DW/8-1:0]        wmask_a [ARBT_NUM];

  for (genvar k = 0; k < ARBT_NUM; k++) begin : g_unpack
    assign addr_a[k]  = i_bus.cmd_addr[k*AW +: AW];
    assign wdata_a[k] = i_bus.cmd_wdata[k*DW +: DW];
    assign wmask_a[k] = i_bus.cmd_wmask[k*(DW/8) +: (DW/8)];
  end

  // First valid requester at or after rr_ptr, wrapping modulo ARBT_NUM.
  always_comb begin
    rr_grant = rr_ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < ARBT_NUM; i++) begin
      idx = ARBT_PTR_W'((int'(rr_ptr) + i) % ARBT_NUM);
      if (!found && i_bus.cmd_valid[idx]) begin
        rr_grant = idx;
        found    = 1'b1;
      end
    end
  end

  assign grant    = (state == ARBT_HOLD) ? lock_id : rr_grant;
  assign cmd_room = fifo_wr_rdy & ~fifo_full;
  assign head_vld = fifo_rd_vld & ~fifo_empty;

  assign o_icb.cmd_valid = rst_n & i_bus.cmd_valid[grant] & cmd_room;
  assign o_icb.cmd_read  = i_bus.cmd_read[grant];
  assign o_icb.cmd_addr  = addr_a[grant];
  assign o_icb.cmd_wdata = wdata_a[grant];
  assign o_icb.cmd_wmask = wmask_a[grant];
  assign cmd_hs          = o_icb.cmd_valid & o_icb.cmd_ready;

  assign o_icb.rsp_ready = rst_n & head_vld & i_bus.rsp_ready[head];
  assign rsp_pop         = o_icb.rsp_valid & o_icb.rsp_ready;

  always_comb begin
    cmd_rdy_vec = '0;
    rsp_vld_vec = '0;
    for (int k = 0; k < ARBT_NUM; k++) begin
      cmd_rdy_vec[k] = rst_n & (grant == ARBT_PTR_W'(k)) & o_icb.cmd_ready & cmd_room;
      rsp_vld_vec[k] = rst_n & (head == ARBT_PTR_W'(k)) & o_icb.rsp_valid & head_vld;
    end
  end

  assign i_bus.cmd_ready = cmd_rdy_vec;
  assign i_bus.rsp_valid = rsp_vld_vec;
  assign i_bus.rsp_err   = {ARBT_NUM{o_icb.rsp_err}};
  assign i_bus.rsp_rdata = {ARBT_NUM{o_icb.rsp_rdata}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARBT_IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        ARBT_IDLE: begin
          if (o_icb.cmd_valid && !o_icb.cmd_ready) begin
            state   <= ARBT_HOLD;
            lock_id <= grant;
          end
        end
        ARBT_HOLD: begin
          if (cmd_hs) state <= ARBT_IDLE;
        end
        default: state <= ARBT_IDLE;
      endcase
      if (cmd_hs) begin
        rr_ptr <= (grant == ARBT_PTR_W'(ARBT_NUM - 1)) ? '0 : grant + ARBT_PTR_W'(1);
      end
    end
  end

  hicore_rspid_fifo #(
    .DW (ARBT_PTR_W),
    .DP (OUTS_NUM)
  ) u_rspid_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (cmd_hs),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat (grant),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (rsp_pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: tb/tb_hicore_icb_rr_arbt.sv
// Directed bench for the round-robin ICB arbiter: 4 requesters, 2 outstanding IDs.
module tb_hicore_icb_rr_arbt;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hicore_icb_rr_arbt_if #(.NUM(N), .AW(AW), .DW(DW)) up ();
  hicore_icb_rr_arbt_if #(.NUM(1), .AW(AW), .DW(DW)) dn ();

  hicore_icb_rr_arbt #(
    .AW(AW), .DW(DW), .ARBT_NUM(N), .ARBT_PTR_W(2), .OUTS_NUM(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_bus (up.slave),
    .o_icb (dn.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] paddr(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [9:0] hs_bits();
    return {dn.cmd_valid, up.cmd_ready, up.rsp_valid, dn.rsp_ready};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    up.cmd_read  = 4'b0101;
    up.cmd_addr  = {paddr(3), paddr(2), paddr(1), paddr(0)};
    up.cmd_wdata = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    up.cmd_wmask = 16'hF3C1;
    up.cmd_valid = '1;
    up.rsp_ready = '1;
    dn.cmd_ready = 1'b1;
    dn.rsp_valid = 1'b1;
    dn.rsp_err   = 1'b0;
    dn.rsp_rdata = 32'h0;
    rst_n        = 1'b0;

    // Reset forces all handshakes low
    settle();
    chk("rst_hs0", 64'(hs_bits()), 64'h0);
    tick();
    settle();
    chk("rst_hs1", 64'(hs_bits()), 64'h0);
    tick();

    // Round robin with immediate responses
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("rr_gnt%0d", c), 64'(up.cmd_ready), 64'(4'b0001 << (c % 4)));
      chk($sformatf("rr_addr%0d", c), 64'(dn.cmd_addr), 64'(paddr(c % 4)));
      chk($sformatf("rr_rsp%0d", c), 64'(up.rsp_valid),
          (c == 0) ? 64'h0 : 64'(4'b0001 << ((c - 1) % 4)));
      tick();
    end
    up.cmd_valid = '0;
    settle();
    chk("rr_tail_rsp", 64'(up.rsp_valid), 64'h1);
    chk("rr_tail_cmd", 64'(dn.cmd_valid), 64'h0);
    tick();

    // Stray response with empty ID FIFO
    settle();
    chk("stray_rdy", 64'(dn.rsp_ready), 64'h0);
    chk("stray_vld", 64'(up.rsp_valid), 64'h0);
    tick();

    // Lock: port 2 offered while downstream stalls (rr_ptr=1)
    dn.rsp_valid = 1'b0;
    dn.cmd_ready = 1'b0;
    up.cmd_valid = 4'b0100;
    settle();
    chk("lock_a_vld", 64'(dn.cmd_valid), 64'h1);
    chk("lock_a_addr", 64'(dn.cmd_addr), 64'(paddr(2)));
    chk("lock_a_rdy", 64'(up.cmd_ready), 64'h0);
    tick();
    up.cmd_valid = 4'b0111;
    settle();
    chk("lock_b_addr", 64'(dn.cmd_addr), 64'(paddr(2)));
    chk("lock_b_wdata", 64'(dn.cmd_wdata), 64'h0000_0000_D2D2_D2D2);
    tick();
    up.cmd_valid = 4'b0011;
    settle();
    chk("lock_drop_vld", 64'(dn.cmd_valid), 64'h0);
    tick();
    up.cmd_valid = 4'b0111;
    dn.cmd_ready = 1'b1;
    settle();
    chk("lock_hs_gnt", 64'(up.cmd_ready), 64'h4);
    chk("lock_hs_read", 64'(dn.cmd_read), 64'h1);
    tick();
    up.cmd_valid = 4'b0011;
    settle();
    chk("lock_next_gnt", 64'(up.cmd_ready), 64'h1);
    tick();

    // Full: IDs {2,0} outstanding; pop in same cycle must not unblock
    up.cmd_valid = 4'b0010;
    dn.rsp_valid = 1'b1;
    dn.rsp_rdata = 32'h5555_0002;
    settle();
    chk("full_vld", 64'(dn.cmd_valid), 64'h0);
    chk("full_rdy", 64'(up.cmd_ready), 64'h0);
    chk("full_rsp_vld", 64'(up.rsp_valid), 64'h4);
    chk("full_rsp_rdy", 64'(dn.rsp_ready), 64'h1);
    tick();
    dn.rsp_valid = 1'b0;
    settle();
    chk("full_next_gnt", 64'(up.cmd_ready), 64'h2);
    tick();

    // Drain {0,1}
    up.cmd_valid = '0;
    dn.rsp_valid = 1'b1;
    dn.rsp_rdata = 32'h1111_0000;
    settle();
    chk("drain0_vld", 64'(up.rsp_valid), 64'h1);
    chk("drain0_data", 64'(up.rsp_rdata[0 +: 32]), 64'h1111_0000);
    tick();
    dn.rsp_rdata = 32'h2222_0001;
    settle();
    chk("drain1_vld", 64'(up.rsp_valid), 64'h2);
    tick();

    // Ordered routing: commands from port 3 then port 1
    dn.rsp_valid = 1'b0;
    up.cmd_valid = 4'b1000;
    settle();
    chk("ord_cmd3", 64'(up.cmd_ready), 64'h8);
    tick();
    up.cmd_valid = 4'b0010;
    settle();
    chk("ord_cmd1", 64'(up.cmd_ready), 64'h2);
    tick();
    up.cmd_valid = '0;
    dn.rsp_valid = 1'b1;
    dn.rsp_rdata = 32'hAAAA_0003;
    up.rsp_ready = 4'b0111;
    settle();
    chk("ord_stall_vld", 64'(up.rsp_valid), 64'h8);
    chk("ord_stall_rdy", 64'(dn.rsp_ready), 64'h0);
    tick();
    up.rsp_ready = '1;
    settle();
    chk("ord_rsp3_vld", 64'(up.rsp_valid), 64'h8);
    chk("ord_rsp3_rdy", 64'(dn.rsp_ready), 64'h1);
    chk("ord_rsp3_data", 64'(up.rsp_rdata[96 +: 32]), 64'hAAAA_0003);
    tick();
    dn.rsp_rdata = 32'h0000_0001;
    dn.rsp_err   = 1'b1;
    settle();
    chk("ord_rsp1_vld", 64'(up.rsp_valid), 64'h2);
    chk("ord_rsp1_data", 64'(up.rsp_rdata[32 +: 32]), 64'h1);
    chk("ord_rsp1_err", 64'(up.rsp_err), 64'hF);
    tick();

    // Reset with two outstanding (ports 1,2; rr_ptr would be 3)
    dn.rsp_valid = 1'b0;
    dn.rsp_err   = 1'b0;
    up.cmd_valid = 4'b0010;
    settle();
    chk("pre_rst_cmd1", 64'(up.cmd_ready), 64'h2);
    tick();
    up.cmd_valid = 4'b0100;
    settle();
    chk("pre_rst_cmd2", 64'(up.cmd_ready), 64'h4);
    tick();
    rst_n        = 1'b0;
    up.cmd_valid = '1;
    dn.rsp_valid = 1'b1;
    settle();
    chk("mid_rst_hs0", 64'(hs_bits()), 64'h0);
    tick();
    settle();
    chk("mid_rst_hs1", 64'(hs_bits()), 64'h0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("post_rst_rsp_rdy", 64'(dn.rsp_ready), 64'h0);
    chk("post_rst_rsp_vld", 64'(up.rsp_valid), 64'h0);
    chk("post_rst_gnt", 64'(up.cmd_ready), 64'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
